imem_boot: RTL and testbench
============================

# imem_boot

Parametrised instruction memory with a built-in boot sequencer. After reset it copies DEPTH words from an external boot-source ROM into its internal array. While copying it holds the pipeline through `boot_busy_o`; afterwards it serves combinational instruction fetches. It sits between the boot-source ROM IP and the IF stage, and replaces the fixed-size, free-running-counter instruction ROM. Its improvements are:
- a real load state machine;
- a configurable source latency;
- a done flag;
- restartable boot;
- out-of-range protection;
- an optional byte-strobed runtime write port.

## Interface
- DATA_W, 32, word width in bits (multiple of 8, power of two)
- DEPTH, 1024, number of words (power of two, ≥ 4)
- ADDR_W, 32, width of the byte address on the fetch and write ports
- SRC_LAT, 1, boot-source read latency in cycles (1..3)
- clk_100MHz  in  1  system clock, all logic on its rising edge
- arst_n  in  1  reset, asynchronous assert, active-low
- boot_start_i  in  1  single-cycle pulse; restarts the boot copy when the block is in DONE
- src_addr_o  out  clog2(DEPTH)  word address to the boot-source ROM
- src_data_i  in  DATA_W  boot-source data, valid SRC_LAT cycles after its address
- boot_busy_o  out  1  high while copying; the core must hold
- boot_done_o  out  1  high when the array is valid
- r_addr_i  in  ADDR_W  fetch byte address
- r_data_o  out  DATA_W  fetched word (combinational)
- w_ena_i  in  1  runtime write enable (IMEM_WPORT_EN only)
- w_addr_i  in  ADDR_W  runtime write byte address (IMEM_WPORT_EN only)
- w_data_i  in  DATA_W  runtime write data (IMEM_WPORT_EN only)
- w_strb_i  in  DATA_W/8  byte strobes (IMEM_WPORT_EN only)

## Operation
- **Word index:** word index = byte address >> clog2(DATA_W/8). The low byte-offset bits are ignored.
- **States:**
  - FETCH: issue source addresses.
  - DRAIN: wait for in-flight source data.
  - DONE: normal operation.
- **Reset:** the state goes to FETCH and `src_addr_o` goes to 0. Outputs reset to `boot_busy_o`=1, `boot_done_o`=0, `r_data_o`=0. The array itself is not reset.
- **FETCH:**
  - `src_addr_o` increments by one each cycle.
  - A SRC_LAT-deep valid/address shift pipeline tags the returning data. Every tagged `src_data_i` is written to array[tag].
  - When `src_addr_o` = DEPTH-1 has been issued, the state goes to DRAIN.
- **DRAIN:** lasts SRC_LAT cycles, retiring the remaining writes. The state then goes to DONE, where `boot_busy_o`=0 and `boot_done_o`=1. Both flags are registered.
- **DONE:**
  - `boot_start_i` returns the state to FETCH at the next edge with `src_addr_o`=0, `boot_busy_o`=1 and `boot_done_o`=0.
  - `boot_start_i` is ignored in FETCH and DRAIN.
- **Read path:**
  - `r_data_o` = array[index] when in DONE and index < DEPTH.
  - Otherwise `r_data_o` = 0. This covers busy and out-of-range reads, and the 0 is forced.
- **Runtime write (macro on):**
  - In DONE, with `w_ena_i`=1 and index < DEPTH, the byte lanes selected by `w_strb_i` are written at the edge.
  - Unselected lanes are kept.
  - Out-of-range writes are dropped.
  - Writes while busy are dropped; the boot copy has priority.
- **Reset mid-boot:** the sequence restarts from address 0. Partially copied contents remain in the array but are not readable until DONE.

## Timing
- **Cycle numbering:** cycle 0 is the first cycle after `arst_n` deasserts.
- **Source address:** in FETCH, `src_addr_o` = i during cycle i.
- **Write edge:** word i is written at edge i+SRC_LAT+1.
- **Done edge:** the last word is written at edge DEPTH+SRC_LAT. `boot_done_o` rises at that same edge, so it is first high in cycle DEPTH+SRC_LAT.
- **Restart latency:** total restart latency from a `boot_start_i` cycle is also DEPTH+SRC_LAT+1 edges until `boot_done_o`.
- **Fetch latency:** 0 cycles (combinational).
- **Read-after-write:** a same-cycle read of the written word returns old data. The read in the following cycle returns new data.

## Configuration
- **IMEM_WPORT_EN defined:** the `w_ena_i`/`w_addr_i`/`w_data_i`/`w_strb_i` ports and the byte-strobed write logic exist.
- **IMEM_WPORT_EN undefined:** those ports are absent and the array is written only by the boot sequencer, which makes it pure ROM after DONE.

## Structure
- **Shared package `imem_pkg`:**
  - state encoding (FETCH/DRAIN/DONE);
  - ZERO_WORD;
  - clog2-derived width constants (index width, strobe width, byte-offset bits);
  - the SRC_LAT limits.
- **Sub-module `imem_boot_seq`:** contains the FSM, the source-address counter and the latency tag pipeline. It outputs `boot_we`, `boot_waddr`, `boot_busy` and `boot_done`.
- **Top level:** holds the array, the read mux and the write arbitration.

## Test plan
- **Cold boot:** DEPTH=32, SRC_LAT=1, source word i = 0xA5000000+i, release reset.
  - `boot_busy_o`=1 through cycle 32 and `boot_done_o` rises in cycle 33.
  - A read of byte address 0x7C returns 0xA500001F.
- **Latency sweep:** SRC_LAT=3, same source.
  - `boot_done_o` is first high in cycle 35.
  - Every word 0..31 matches; there are no off-by-one shifts.
- **Busy and out-of-range reads:**
  - A read of 0x10 during FETCH returns 0.
  - After DONE, a read of 0x80 (index 32) returns 0 and 0x10 returns 0xA5000004.
- **Reset mid-boot:** pulse `arst_n` low at cycle 10.
  - `src_addr_o` returns to 0 and `boot_done_o` rises 33 cycles after release.
  - Contents are correct.
- **Restart:**
  - `boot_start_i` in DONE with the source changed to 0x5A000000+i: `boot_done_o` drops next cycle, the full reload occurs, and new values are read back.
  - A `boot_start_i` pulse during FETCH is ignored; timing is unchanged.
- **Write port (IMEM_WPORT_EN):**
  - In DONE, write 0x11223344 to 0x08 with strobe 0b0101: the following read of 0x08 returns 0xA5220044.
  - A write during FETCH leaves no effect.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-loaded instruction memory.
// Width helpers derive index/strobe/offset widths from the module parameters.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } boot_state_t;

  localparam int SRC_LAT_MIN = 1;
  localparam int SRC_LAT_MAX = 3;

  // Wide enough for any practical word; callers size-cast it down.
  localparam logic [1023:0] ZERO_WORD = '0;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int clamp_lat(input int lat);
    if (lat < SRC_LAT_MIN) return SRC_LAT_MIN;
    if (lat > SRC_LAT_MAX) return SRC_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/imem_boot_seq.sv
// Boot copy sequencer: source-address counter, load FSM and the latency tag
// pipeline that pairs returning source data with its array index.
//
// state    | meaning
// ST_FETCH | issue one source address per cycle, 0..DEPTH-1
// ST_DRAIN | retire the SRC_LAT writes still in flight
// ST_DONE  | array valid; boot_start_i restarts the copy
module imem_boot_seq
  import imem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int SRC_LAT = 1,
  parameter int IDX_W   = idx_width(DEPTH)
) (
  input  logic             clk_100MHz,
  input  logic             arst_n,
  input  logic             boot_start_i,
  output logic [IDX_W-1:0] src_addr_o,
  output logic             boot_we,
  output logic [IDX_W-1:0] boot_waddr,
  output logic             boot_busy,
  output logic             boot_done
);

  localparam int               LAT        = clamp_lat(SRC_LAT);
  localparam int               CNT_W      = 2;
  localparam logic [IDX_W-1:0] LAST_ADDR  = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(LAT - 1);

  boot_state_t      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_src_addr, w_src_addr_nxt;
  logic [CNT_W-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic             r_busy, r_done;
  logic             w_issue;
  logic [LAT-1:0]   r_vld;
  logic [IDX_W-1:0] r_tag [LAT];

  always_comb begin
    w_state_nxt     = r_state;
    w_src_addr_nxt  = r_src_addr;
    w_drain_cnt_nxt = r_drain_cnt;
    w_issue         = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        w_issue = 1'b1;
        if (r_src_addr == LAST_ADDR) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = DRAIN_LOAD;
        end else begin
          w_src_addr_nxt = r_src_addr + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) w_state_nxt = ST_DONE;
        else w_drain_cnt_nxt = r_drain_cnt - 1'b1;
      end
      ST_DONE: begin
        if (boot_start_i) begin
          w_state_nxt    = ST_FETCH;
          w_src_addr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ST_FETCH;
        w_src_addr_nxt = '0;
      end
    endcase
  end

  // Flags are registered from the next state so they switch on the same edge.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= ST_FETCH;
      r_src_addr  <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_src_addr  <= w_src_addr_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_busy      <= (w_state_nxt != ST_DONE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      r_vld[0] <= w_issue;
      r_tag[0] <= r_src_addr;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign src_addr_o = r_src_addr;
  assign boot_we    = r_vld[LAT-1];
  assign boot_waddr = r_tag[LAT-1];
  assign boot_busy  = r_busy;
  assign boot_done  = r_done;

endmodule

// File: rtl/imem_boot.sv
// Instruction memory that self-loads DEPTH words from a boot ROM after reset.
// Optional byte-strobed runtime write port enabled by macro IMEM_WPORT_EN.
module imem_boot
  import imem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int SRC_LAT = 1
) (
  input  logic                      clk_100MHz,
  input  logic                      arst_n,
  input  logic                      boot_start_i,
  output logic [$clog2(DEPTH)-1:0]  src_addr_o,
  input  logic [DATA_W-1:0]         src_data_i,
  output logic                      boot_busy_o,
  output logic                      boot_done_o,
`ifdef IMEM_WPORT_EN
  input  logic                      w_ena_i,
  input  logic [ADDR_W-1:0]         w_addr_i,
  input  logic [DATA_W-1:0]         w_data_i,
  input  logic [DATA_W/8-1:0]       w_strb_i,
`endif
  input  logic [ADDR_W-1:0]         r_addr_i,
  output logic [DATA_W-1:0]         r_data_o
);

  localparam int IDX_W    = idx_width(DEPTH);
  localparam int OFF_BITS = off_bits(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_boot_we;
  logic [IDX_W-1:0]  w_boot_waddr;
  logic              w_busy, w_done;
  logic [ADDR_W-1:0] w_ridx;
  logic              w_rd_in_range;

  imem_boot_seq #(
    .DEPTH   (DEPTH),
    .SRC_LAT (SRC_LAT),
    .IDX_W   (IDX_W)
  ) u_seq (
    .clk_100MHz   (clk_100MHz),
    .arst_n       (arst_n),
    .boot_start_i (boot_start_i),
    .src_addr_o   (src_addr_o),
    .boot_we      (w_boot_we),
    .boot_waddr   (w_boot_waddr),
    .boot_busy    (w_busy),
    .boot_done    (w_done)
  );

  assign boot_busy_o = w_busy;
  assign boot_done_o = w_done;

`ifdef IMEM_WPORT_EN
  localparam int STRB_W = strb_width(DATA_W);

  logic [ADDR_W-1:0] w_widx;
  logic              w_wr_ok;

  assign w_widx  = w_addr_i >> OFF_BITS;
  assign w_wr_ok = w_done && w_ena_i && (w_widx < ADDR_W'(DEPTH));

  // Boot copy and runtime writes never overlap in time, but boot wins if they did.
  always_ff @(posedge clk_100MHz) begin
    if (w_boot_we) begin
      r_mem[w_boot_waddr] <= src_data_i;
    end else if (w_wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_i[b]) r_mem[w_widx[IDX_W-1:0]][b*8 +: 8] <= w_data_i[b*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk_100MHz) begin
    if (w_boot_we) r_mem[w_boot_waddr] <= src_data_i;
  end
`endif

  assign w_ridx        = r_addr_i >> OFF_BITS;
  assign w_rd_in_range = (w_ridx < ADDR_W'(DEPTH));

  // Full-width range check so high address bits never alias into the array.
  always_comb begin
    r_data_o = DATA_W'(ZERO_WORD);
    if (w_done && w_rd_in_range) r_data_o = r_mem[w_ridx[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_imem_boot.sv
// Scoreboard bench for imem_boot: two instances (SRC_LAT 1 and 3, DEPTH 32)
// fed from a modelled boot ROM; write-port checks need IMEM_WPORT_EN.
`timescale 1ns/1ps
module tb_imem_boot;

  localparam int S_RD1 = 0, S_BUSY1 = 1, S_DONE1 = 2, S_SA1 = 3;
  localparam int S_RD3 = 4, S_DONE3 = 5, S_BUSY3 = 6, S_SA3 = 7;

  logic        clk = 1'b0;
  logic        arst_n, boot_start;
  logic [31:0] base;
  logic [4:0]  sa1, sa3, ap1;
  logic [4:0]  ap3 [3];
  logic [31:0] sd1, sd3, ra1, ra3, rd1, rd3;
  logic        busy1, done1, busy3, done3;
`ifdef IMEM_WPORT_EN
  logic        we;
  logic [31:0] wa, wd;
  logic [3:0]  ws;
`endif

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  // Boot ROM model: data for address A appears SRC_LAT cycles after A is issued.
  always @(posedge clk) begin
    ap1    <= sa1;
    ap3[0] <= sa3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign sd1 = base + {27'd0, ap1};
  assign sd3 = base + {27'd0, ap3[2]};

  imem_boot #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .SRC_LAT(1)) dut1 (
    .clk_100MHz(clk), .arst_n(arst_n), .boot_start_i(boot_start),
    .src_addr_o(sa1), .src_data_i(sd1), .boot_busy_o(busy1), .boot_done_o(done1),
`ifdef IMEM_WPORT_EN
    .w_ena_i(we), .w_addr_i(wa), .w_data_i(wd), .w_strb_i(ws),
`endif
    .r_addr_i(ra1), .r_data_o(rd1)
  );

  imem_boot #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .SRC_LAT(3)) dut3 (
    .clk_100MHz(clk), .arst_n(arst_n), .boot_start_i(boot_start),
    .src_addr_o(sa3), .src_data_i(sd3), .boot_busy_o(busy3), .boot_done_o(done3),
`ifdef IMEM_WPORT_EN
    .w_ena_i(we), .w_addr_i(wa), .w_data_i(wd), .w_strb_i(ws),
`endif
    .r_addr_i(ra3), .r_data_o(rd3)
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_RD1:   return rd1;
      S_BUSY1: return {31'd0, busy1};
      S_DONE1: return {31'd0, done1};
      S_SA1:   return {27'd0, sa1};
      S_RD3:   return rd3;
      S_DONE3: return {31'd0, done3};
      S_BUSY3: return {31'd0, busy3};
      default: return {27'd0, sa3};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      total++;
      if (obs(c.sel) !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, obs(c.sel), c.exp, cyc);
      end
    end
  end

  task automatic push_exp(input int sel, input logic [31:0] exp, input string name);
    q.push_back('{sel, exp, name});
  endtask

  task automatic check_now(input int sel, input logic [31:0] exp, input string name);
    total++;
    if (obs(sel) !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (immediate)", name, obs(sel), exp);
    end
  endtask

  task automatic wait_done1(input int limit);
    int n;
    n = 0;
    while (done1 !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (done1 !== 1'b1) begin
      bad++;
      $display("FAIL wait_done1: timeout after %0d cycles", limit);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) tick();
  endtask

  // Completion timing, full readback and out-of-range reads for a boot with source base b.
  task automatic finish_boot(input logic [31:0] b);
    go(32);
    push_exp(S_BUSY1, 32'd1, "busy1_c32");
    push_exp(S_DONE1, 32'd0, "done1_c32");
    go(33);
    push_exp(S_BUSY1, 32'd0, "busy1_c33");
    push_exp(S_DONE1, 32'd1, "done1_c33");
    ra1 = 32'h7C;
    push_exp(S_RD1, b + 32'd31, "rd1_last_word");
    go(34);
    push_exp(S_DONE3, 32'd0, "done3_c34");
    push_exp(S_BUSY3, 32'd1, "busy3_c34");
    go(35);
    push_exp(S_DONE3, 32'd1, "done3_c35");
    push_exp(S_BUSY3, 32'd0, "busy3_c35");
    for (int i = 0; i < 32; i++) begin
      tick();
      ra1 = i * 4;
      ra3 = i * 4 + (i % 4);
      push_exp(S_RD1, b + i, $sformatf("rd1_word%0d", i));
      push_exp(S_RD3, b + i, $sformatf("rd3_word%0d", i));
    end
    tick();
    ra1 = 32'h80;
    ra3 = 32'h10;
    push_exp(S_RD1, 32'd0, "rd1_oob_0x80");
    push_exp(S_RD3, b + 32'd4, "rd3_0x10");
    tick();
    ra1 = 32'h0001_0010;
    ra3 = 32'hFFFF_FFFC;
    push_exp(S_RD1, 32'd0, "rd1_oob_high");
    push_exp(S_RD3, 32'd0, "rd3_oob_top");
  endtask

  initial begin
    arst_n     = 1'b0;
    boot_start = 1'b0;
    base       = 32'hA500_0000;
    ra1        = '0;
    ra3        = '0;
`ifdef IMEM_WPORT_EN
    we = 1'b0; wa = '0; wd = '0; ws = '0;
`endif

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_now(S_BUSY1, 32'd1, "rst_busy1");
    check_now(S_DONE1, 32'd0, "rst_done1");
    check_now(S_SA1,   32'd0, "rst_src_addr1");
    check_now(S_RD1,   32'd0, "rst_rdata1");
    check_now(S_BUSY3, 32'd1, "rst_busy3");
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    cyc    = 0;

    // Cold boot
    push_exp(S_SA1, 32'd0, "sa1_c0");
    push_exp(S_SA3, 32'd0, "sa3_c0");
    go(5);
    ra1        = 32'h10;
    boot_start = 1'b1;
    push_exp(S_RD1, 32'd0, "busy_read_0x10");
    push_exp(S_SA1, 32'd5, "sa1_c5");
    go(6);
    boot_start = 1'b0;
    push_exp(S_SA1, 32'd6, "sa1_c6_start_ignored");
`ifdef IMEM_WPORT_EN
    go(20);
    we = 1'b1; wa = 32'h08; wd = 32'hDEAD_BEEF; ws = 4'hF;
    tick();
    we = 1'b0;
`endif
    finish_boot(32'hA500_0000);

`ifdef IMEM_WPORT_EN
    tick();
    we = 1'b1; wa = 32'h08; wd = 32'h1122_3344; ws = 4'b0101;
    ra1 = 32'h08; ra3 = 32'h08;
    push_exp(S_RD1, 32'hA500_0002, "raw_same_cycle1");
    push_exp(S_RD3, 32'hA500_0002, "raw_same_cycle3");
    tick();
    we = 1'b0;
    push_exp(S_RD1, 32'hA522_0044, "strb_write1");
    push_exp(S_RD3, 32'hA522_0044, "strb_write3");
    tick();
    we = 1'b1; wa = 32'h88; wd = 32'hFFFF_FFFF; ws = 4'hF;
    tick();
    we = 1'b0;
    push_exp(S_RD1, 32'hA522_0044, "oob_write_dropped");
`endif

    // Restart from DONE with a new source image
    tick();
    base       = 32'h5A00_0000;
    boot_start = 1'b1;
    push_exp(S_DONE1, 32'd1, "done1_at_start");
    tick();
    boot_start = 1'b0;
    cyc        = 0;
    push_exp(S_DONE1, 32'd0, "done1_dropped");
    push_exp(S_BUSY1, 32'd1, "busy1_restart");
    push_exp(S_SA1,   32'd0, "sa1_restart");
    push_exp(S_SA3,   32'd0, "sa3_restart");
    go(5);
    ra1        = 32'h10;
    boot_start = 1'b1;
    push_exp(S_RD1, 32'd0, "restart_busy_read");
    go(6);
    boot_start = 1'b0;
`ifdef IMEM_WPORT_EN
    go(20);
    we = 1'b1; wa = 32'h0C; wd = 32'h0BAD_F00D; ws = 4'hF;
    tick();
    we = 1'b0;
`endif
    finish_boot(32'h5A00_0000);

    // Reset mid-boot
    tick();
    base   = 32'hA500_0000;
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    cyc    = 0;
    go(10);
    arst_n = 1'b0;
    push_exp(S_SA1,   32'd0, "midrst_sa1");
    push_exp(S_SA3,   32'd0, "midrst_sa3");
    push_exp(S_BUSY1, 32'd1, "midrst_busy1");
    push_exp(S_DONE1, 32'd0, "midrst_done1");
    tick();
    arst_n = 1'b1;
    cyc    = 0;
    push_exp(S_SA1, 32'd0, "midrst_sa1_c0");
    finish_boot(32'hA500_0000);

    tick();
    wait_done1(100);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
